// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up at the end, register-file writeback port.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_rd,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [XLEN-1:0] req_rs2_data,
  input  logic            kill,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            wb_we,
  output logic [4:0]      wb_waddr,
  output logic [XLEN-1:0] wb_wdata
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [4:0]          rd_reg;
  logic [2*XLEN-1:0]   a_reg;     // multiplicand (shifts left) / dividend becoming quotient
  logic [XLEN-1:0]     b_reg;     // multiplier (shifts right) / divisor
  logic [2*XLEN:0]     acc_reg;   // product accumulator / partial remainder
  logic [CNT_W-1:0]    cnt_reg;
  logic                neg_reg;
  logic [XLEN-1:0]     result_reg;

  logic                accept;
  logic                sign_a, sign_b, neg_in;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [2*XLEN:0]     mul_add;
  logic [XLEN:0]       rem_sh, diff;
  logic                q_bit;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     fix_result;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign wb_we     = rsp_valid & rsp_ready & (rd_reg != 5'd0);
  assign wb_waddr  = rd_reg;
  assign wb_wdata  = result_reg;
  assign accept    = req_valid & req_ready & ~kill;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    neg_in = 1'b0;
    if (req_op == OP_MULH || req_op == OP_MULHSU || req_op == OP_DIV || req_op == OP_REM)
      sign_a = req_rs1_data[XLEN-1];
    if (req_op == OP_MULH || req_op == OP_DIV || req_op == OP_REM)
      sign_b = req_rs2_data[XLEN-1];
    abs_a = sign_a ? -req_rs1_data : req_rs1_data;
    abs_b = sign_b ? -req_rs2_data : req_rs2_data;
    // Divide by zero must yield an all-ones quotient, so the quotient is never negated then.
    if (req_op[2] && !req_op[1])
      neg_in = (sign_a ^ sign_b) & (req_rs2_data != '0);
    else if (req_op[2])
      neg_in = sign_a;
    else
      neg_in = sign_a ^ sign_b;
  end

  always_comb begin
    mul_add = b_reg[0] ? {1'b0, a_reg} : '0;
    rem_sh  = {acc_reg[XLEN-1:0], a_reg[XLEN-1]};
    diff    = rem_sh - {1'b0, b_reg};
    q_bit   = ~diff[XLEN];
  end

  always_comb begin
    prod_fix = neg_reg ? -acc_reg[2*XLEN-1:0] : acc_reg[2*XLEN-1:0];
    case (op_reg)
      OP_MUL:          fix_result = prod_fix[XLEN-1:0];
      OP_DIV, OP_DIVU: fix_result = neg_reg ? -a_reg[XLEN-1:0] : a_reg[XLEN-1:0];
      OP_REM, 3'd7:    fix_result = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
      default:         fix_result = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (req_valid) state_next = BUSY;
        BUSY:    if (cnt_reg == LAST_STEP) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    if (rsp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
    end else if (accept) begin
      op_reg  <= req_op;
      rd_reg  <= req_rd;
      a_reg   <= {{XLEN{1'b0}}, abs_a};
      b_reg   <= abs_b;
      acc_reg <= '0;
      cnt_reg <= '0;
      neg_reg <= neg_in;
    end else if (!kill && state_reg == BUSY) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (op_reg[2]) begin
        acc_reg <= {{XLEN{1'b0}}, (q_bit ? diff : rem_sh)};
        a_reg   <= {a_reg[2*XLEN-2:0], q_bit};
      end else begin
        acc_reg <= acc_reg + mul_add;
        a_reg   <= {a_reg[2*XLEN-2:0], 1'b0};
        b_reg   <= {1'b0, b_reg[XLEN-1:1]};
      end
    end else if (!kill && state_reg == FIX) begin
      result_reg <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, latency, backpressure,
// kill and asynchronous reset mid-operation.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_rs1_data, req_rs2_data;
  logic        kill, rsp_valid, rsp_ready, wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .kill(kill), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wb_we) we_count <= we_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns one cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1_data = a; req_rs2_data = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int w0;
    rsp_ready = 1'b1;
    issue(op, rd, a, b);
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check({tag, "_wdata"}, wb_wdata, exp);
    check({tag, "_waddr"}, 32'(wb_waddr), 32'(rd));
    check({tag, "_we"}, 32'(wb_we), 32'(rd != 5'd0));
    w0 = we_count;
    tick();
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_we_pulses"}, 32'(we_count - w0), 32'(rd != 5'd0));
    $display("%s op=%0d rd=%0d a=%h b=%h -> wdata=%h lat=%0d", tag, op, rd, a, b, exp, lat);
  endtask

  initial begin
    int lat;
    int w0;
    logic [31:0] held;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0;
    req_rs1_data = '0; req_rs2_data = '0; kill = 1'b0; rsp_ready = 1'b0;
    #12;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_wb_we", 32'(wb_we), 32'd0);
    check("reset_waddr", 32'(wb_waddr), 32'd0);
    check("reset_wdata", wb_wdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_op("mul",       3'd0, 5'd5,  32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB);
    do_op("mulh",      3'd1, 5'd1,  32'h80000000,  32'h80000000, 32'h40000000);
    do_op("mulhsu",    3'd2, 5'd2,  32'h80000000,  32'h80000000, 32'hC0000000);
    do_op("mulhu",     3'd3, 5'd3,  32'h80000000,  32'h80000000, 32'h40000000);
    do_op("divu_by0",  3'd5, 5'd4,  32'd100,       32'd0,        32'hFFFFFFFF);
    do_op("remu_by0",  3'd7, 5'd6,  32'd100,       32'd0,        32'd100);
    do_op("div_ovf",   3'd4, 5'd8,  32'h80000000,  32'hFFFFFFFF, 32'h80000000);
    do_op("rem_ovf",   3'd6, 5'd9,  32'h80000000,  32'hFFFFFFFF, 32'd0);
    do_op("div_neg",   3'd4, 5'd10, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD);
    do_op("rem_neg",   3'd6, 5'd11, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF);
    do_op("div_neg_by0", 3'd4, 5'd12, 32'hFFFFFFF9, 32'd0,       32'hFFFFFFFF);
    do_op("rem_neg_by0", 3'd6, 5'd13, 32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9);
    do_op("mul_rd0",   3'd0, 5'd0,  32'd5,         32'd6,        32'd30);

    // Backpressure: result must hold in DONE until rsp_ready rises, then write exactly once.
    rsp_ready = 1'b0;
    issue(3'd5, 5'd12, 32'd1000, 32'd7);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd34);
    held = wb_wdata;
    check("bp_wdata", held, 32'd142);
    w0 = we_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_wdata_held", wb_wdata, 32'd142);
      check("bp_waddr_held", 32'(wb_waddr), 32'd12);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
      check("bp_we_low", 32'(wb_we), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_we_on_ready", 32'(wb_we), 32'd1);
    tick();
    tick();
    check("bp_rsp_done", 32'(rsp_valid), 32'd0);
    check("bp_one_pulse", 32'(we_count - w0), 32'd1);
    $display("backpressure divu 1000/7 held 10 cycles -> wdata=%h", held);

    // Kill at BUSY step 10 with a competing request that must not be taken.
    w0 = we_count;
    issue(3'd0, 5'd13, 32'd9, 32'd9);
    repeat (9) tick();
    kill = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rd = 5'd14;
    req_rs1_data = 32'd1; req_rs2_data = 32'd1;
    tick();
    kill = 1'b0; req_valid = 1'b0;
    check("kill_idle", 32'(req_ready), 32'd1);
    check("kill_rsp_low", 32'(rsp_valid), 32'd0);
    tick();
    check("kill_no_accept", 32'(req_ready), 32'd1);
    repeat (40) tick();
    check("kill_no_rsp", 32'(rsp_valid), 32'd0);
    check("kill_no_we", 32'(we_count - w0), 32'd0);
    $display("kill mul 9*9 at step 10 -> dropped");

    // Asynchronous reset at BUSY step 20 with req_valid high.
    w0 = we_count;
    issue(3'd4, 5'd15, 32'd50, 32'd5);
    repeat (19) tick();
    req_valid = 1'b1; req_op = 3'd0; req_rd = 5'd16; req_rs1_data = 32'd2; req_rs2_data = 32'd2;
    #2 rst = 1'b1;
    #1;
    check("rst_async_idle", 32'(req_ready), 32'd1);
    check("rst_async_rsp", 32'(rsp_valid), 32'd0);
    check("rst_async_waddr", 32'(wb_waddr), 32'd0);
    check("rst_async_wdata", wb_wdata, 32'd0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    repeat (40) tick();
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_no_we", 32'(we_count - w0), 32'd0);
    $display("reset during div 50/5 at step 20 -> dropped");

    do_op("mul_after_rst", 3'd0, 5'd7, 32'd3, 32'd4, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
